slot_arbiter: RTL and testbench

- Round-robin time-slot arbiter that shares one counted resource among N_REQ requesters.
- Each winner holds a grant for at most SLOT_LEN cycles, timed by an internal modulo-SLOT_LEN slot counter (same mod-N counter style as the team's 4-bit counters).
- The grantee may release its slot early.
- Sits between requesting client blocks and the shared counter/datapath.
- Its one-hot gnt vector drives that resource's enable/select.

---
 rtl/slot_arb_pkg.sv | 12 +
 rtl/slot_arbiter_timer.sv | 32 +++
 rtl/slot_arbiter.sv | 111 +++++++++++
 tb/tb_slot_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/slot_arb_pkg.sv
// Shared constants for the round-robin time-slot arbiter:
// FSM state encodings, slot counter width and default slot length.
package slot_arb_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] GAP   = 2'b10;

  localparam int unsigned SLOT_CNT_W       = 4;
  localparam int unsigned SLOT_LEN_DEFAULT = 14;

endpackage

// File: rtl/slot_arbiter_timer.sv
// Modulo-SLOT_LEN slot counter: counts cycles elapsed in the current grant,
// flags the final cycle of the slot.
module slot_timer
  import slot_arb_pkg::*;
#(
  parameter int unsigned SLOT_LEN = SLOT_LEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  clr,
  output logic [SLOT_CNT_W-1:0] cnt,
  output logic                  last
);

  logic [SLOT_CNT_W-1:0] r_cnt;
  logic                  w_last;

  assign w_last = (r_cnt == SLOT_CNT_W'(SLOT_LEN - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + SLOT_CNT_W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign last = w_last;

endmodule

// File: rtl/slot_arbiter.sv
// Round-robin time-slot arbiter: one-hot registered grant held for at most
// SLOT_LEN cycles, early release on done/req drop, one idle cycle between grants.
module slot_arbiter
  import slot_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned SLOT_LEN = SLOT_LEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      done,
  output logic [N_REQ-1:0]      gnt,
  output logic                  busy,
  output logic [SLOT_CNT_W-1:0] slot_cnt,
  output logic                  slot_end
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [1:0]            r_state;
  logic [N_REQ-1:0]      r_gnt;
  logic                  r_busy;
  logic [PTR_W-1:0]      r_ptr;

  logic                  w_grant;
  logic                  w_release;
  logic                  w_last;
  logic                  w_slot_end;
  logic [SLOT_CNT_W-1:0] w_cnt;
  logic [PTR_W:0]        w_pick;
  logic                  w_found;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W-1:0]      w_ptr_next;

  // Two passes: indices at/above the pointer first, then wrap to the bottom.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [PTR_W-1:0] p);
    logic [PTR_W:0] res;
    res = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!res[PTR_W] && (j >= 32'(p)) && r[j]) res = {1'b1, PTR_W'(j)};
    end
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!res[PTR_W] && r[j]) res = {1'b1, PTR_W'(j)};
    end
    return res;
  endfunction

  assign w_pick     = rr_pick(req, r_ptr);
  assign w_found    = w_pick[PTR_W];
  assign w_win      = w_pick[PTR_W-1:0];
  assign w_ptr_next = (w_win == PTR_W'(N_REQ - 1)) ? '0 : w_win + PTR_W'(1);

  assign w_grant    = (r_state == GRANT);
  assign w_slot_end = w_grant && w_last;
  assign w_release  = w_grant && (w_slot_end || (|(done & r_gnt)) || !(|(req & r_gnt)));

  slot_timer #(.SLOT_LEN(SLOT_LEN)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_grant && !w_release),
    .clr     (!w_grant || w_release),
    .cnt     (w_cnt),
    .last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE, GAP: begin
          if (w_found) begin
            r_state <= GRANT;
            r_gnt   <= N_REQ'(1) << w_win;
            r_busy  <= 1'b1;
            r_ptr   <= w_ptr_next;
          end else begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state <= GAP;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign busy     = r_busy;
  assign slot_cnt = w_cnt;
  assign slot_end = w_slot_end;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(r_gnt));

endmodule

// File: tb/tb_slot_arbiter.sv
// Directed self-checking bench for slot_arbiter (N_REQ=4, SLOT_LEN=14).
module tb_slot_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       busy;
  logic [3:0] slot_cnt;
  logic       slot_end;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  slot_arbiter #(.N_REQ(4), .SLOT_LEN(14)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .busy     (busy),
    .slot_cnt (slot_cnt),
    .slot_end (slot_end)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] r);
    reset_n = 1'b0;
    req     = r;
    done    = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 4'b1111;
    done    = '0;
    step();
    step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (slot_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", slot_cnt); end
    tests++; if (slot_end !== 1'b0) begin fails++; $display("FAIL reset_slot_end got %b exp 0", slot_end); end
    reset_n = 1'b1;
    step();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL reset_first_gnt got %b exp 0001", gnt); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_first_busy got %b exp 1", busy); end
    tests++; if (slot_cnt !== 4'd0) begin fails++; $display("FAIL reset_first_cnt got %0d exp 0", slot_cnt); end
  endtask

  task automatic test_single();
    int ph;
    logic [3:0] eg, ec;
    do_reset(4'b0001);
    for (int c = 0; c < 30; c++) begin
      step();
      ph = c % 15;
      eg = (ph < 14) ? 4'b0001 : 4'b0000;
      ec = (ph < 14) ? 4'(ph) : 4'd0;
      tests++; if (gnt !== eg) begin fails++; $display("FAIL single_gnt c=%0d got %b exp %b", c, gnt, eg); end
      tests++; if (slot_cnt !== ec) begin fails++; $display("FAIL single_cnt c=%0d got %0d exp %0d", c, slot_cnt, ec); end
      tests++; if (slot_end !== (ph == 13)) begin fails++; $display("FAIL single_slot_end c=%0d got %b exp %b", c, slot_end, ph == 13); end
      tests++; if (busy !== (ph < 14)) begin fails++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy, ph < 14); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset(4'b1111);
    for (int g = 0; g < 5; g++) begin
      eg = 4'(1 << (g % 4));
      for (int k = 0; k < 14; k++) begin
        step();
        tests++; if (gnt !== eg) begin fails++; $display("FAIL rr_gnt g=%0d k=%0d got %b exp %b", g, k, gnt, eg); end
        tests++; if (slot_cnt !== 4'(k)) begin fails++; $display("FAIL rr_cnt g=%0d k=%0d got %0d exp %0d", g, k, slot_cnt, k); end
      end
      if (g < 4) begin
        step();
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL rr_gap g=%0d got %b exp 0000", g, gnt); end
      end
    end
  endtask

  // done pattern d is pulsed while slot_cnt==3; hold is the expected grant length.
  task automatic test_early_release(input logic [3:0] d, input int hold);
    logic [3:0] eg, ec;
    do_reset(4'b0100);
    for (int c = 0; c <= hold + 1; c++) begin
      step();
      eg = (c == hold) ? 4'b0000 : 4'b0100;
      ec = (c < hold) ? 4'(c) : 4'd0;
      tests++; if (gnt !== eg) begin fails++; $display("FAIL early_gnt d=%b c=%0d got %b exp %b", d, c, gnt, eg); end
      tests++; if (slot_cnt !== ec) begin fails++; $display("FAIL early_cnt d=%b c=%0d got %0d exp %0d", d, c, slot_cnt, ec); end
      done = (c == 3) ? d : 4'b0000;
    end
    done = '0;
  endtask

  task automatic test_req_drop();
    logic [3:0] eg;
    do_reset(4'b0011);
    for (int c = 0; c < 8; c++) begin
      step();
      eg = (c < 6) ? 4'b0001 : ((c == 6) ? 4'b0000 : 4'b0010);
      tests++; if (gnt !== eg) begin fails++; $display("FAIL drop_gnt c=%0d got %b exp %b", c, gnt, eg); end
      if (c == 5) req = 4'b0010;
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset(4'b0100);
    for (int c = 0; c < 8; c++) step();
    tests++; if (gnt !== 4'b0100 || slot_cnt !== 4'd7) begin
      fails++; $display("FAIL midrst_pre got gnt=%b cnt=%0d exp gnt=0100 cnt=7", gnt, slot_cnt);
    end
    reset_n = 1'b0;
    req     = 4'b1111;
    step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL midrst_gnt got %b exp 0000", gnt); end
    tests++; if (slot_cnt !== 4'd0) begin fails++; $display("FAIL midrst_cnt got %0d exp 0", slot_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b exp 0", busy); end
    reset_n = 1'b1;
    step();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL midrst_after got %b exp 0001", gnt); end
  endtask

  task automatic test_idle_latency();
    do_reset(4'b0000);
    for (int c = 0; c < 3; c++) begin
      step();
      tests++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
        fails++; $display("FAIL idle_hold c=%0d got gnt=%b busy=%b exp gnt=0000 busy=0", c, gnt, busy);
      end
    end
    req = 4'b1000;
    step();
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL idle_latency got %b exp 1000", gnt); end
    req = 4'b0000;
    step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL idle_drop got %b exp 0000", gnt); end
    step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL idle_return got %b exp 0000", gnt); end
    req = 4'b0011;
    step();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL idle_ptr_wrap got %b exp 0001", gnt); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req     = '0;
    done    = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release(4'b0100, 4);
    test_early_release(4'b0010, 14);
    test_req_drop();
    test_reset_mid_grant();
    test_idle_latency();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
